// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
// Parity support in uart_tx_ctrl is enabled by defining UART_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int UART_OS_DEFAULT = 16;

    // Tick counter must hold the larger of the bit period and the stop period.
    function automatic int tick_cnt_width(input int os, input int sb_tick);
        int m;
        m = (os > sb_tick) ? os : sb_tick;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start / DBIT data (LSB first) / [parity] / stop.
// Define UART_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int OS      = UART_OS_DEFAULT,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic [DBIT-1:0] tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    input  logic            parity_odd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int SW = tick_cnt_width(OS, SB_TICK);
    localparam int NW = $clog2(DBIT);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_START  = START;
    localparam logic [2:0] S_DATA   = DATA;
    localparam logic [2:0] S_PARITY = PARITY;
    localparam logic [2:0] S_STOP   = STOP;

    localparam logic [SW-1:0] OS_LAST = SW'(OS - 1);
    localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

    logic [2:0]      state_reg, state_next;
    logic [SW-1:0]   s_cnt, s_next;
    logic [NW-1:0]   n_cnt, n_next;
    logic [DBIT-1:0] shift_reg, shift_next;
    logic            tx_reg, tx_line;

`ifdef UART_PARITY_EN
    logic par_reg, par_next;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    always_comb begin
        state_next   = state_reg;
        s_next       = s_cnt;
        n_next       = n_cnt;
        shift_next   = shift_reg;
        tx_done_tick = 1'b0;
`ifdef UART_PARITY_EN
        par_next     = par_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                // A tick coinciding with the handshake is deliberately dropped.
                if (tx_valid) begin
                    shift_next = tx_data;
                    s_next     = '0;
                    n_next     = '0;
`ifdef UART_PARITY_EN
                    par_next   = (^tx_data) ^ parity_odd;
`endif
                    state_next = S_START;
                end
            end
            S_START: begin
                if (s_tick) begin
                    if (s_cnt == OS_LAST) begin
                        s_next     = '0;
                        state_next = S_DATA;
                    end else begin
                        s_next = s_cnt + SW'(1);
                    end
                end
            end
            S_DATA: begin
                if (s_tick) begin
                    if (s_cnt == OS_LAST) begin
                        s_next     = '0;
                        shift_next = shift_reg >> 1;
                        if (n_cnt == N_LAST) begin
`ifdef UART_PARITY_EN
                            state_next = S_PARITY;
`else
                            state_next = S_STOP;
`endif
                        end else begin
                            n_next = n_cnt + NW'(1);
                        end
                    end else begin
                        s_next = s_cnt + SW'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (s_tick) begin
                    if (s_cnt == OS_LAST) begin
                        s_next     = '0;
                        state_next = S_STOP;
                    end else begin
                        s_next = s_cnt + SW'(1);
                    end
                end
            end
`endif
            S_STOP: begin
                if (s_tick) begin
                    if (s_cnt == SB_LAST) begin
                        s_next       = '0;
                        state_next   = S_IDLE;
                        tx_done_tick = 1'b1;
                    end else begin
                        s_next = s_cnt + SW'(1);
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Line level for the current state; registered so tx lags the state by one clk.
    always_comb begin
        tx_line = 1'b1;
        case (state_reg)
            S_START:  tx_line = 1'b0;
            S_DATA:   tx_line = shift_reg[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx_line = par_reg;
`endif
            default:  tx_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            s_cnt     <= '0;
            n_cnt     <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            s_cnt     <= s_next;
            n_cnt     <= n_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_line;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) par_reg <= 1'b0;
        else          par_reg <= par_next;
    end
`endif

    assign tx       = tx_reg;
    assign tx_ready = (state_reg == S_IDLE);
    assign tx_busy  = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized bench for uart_tx_ctrl against a tick-count line model.
// Honours UART_PARITY_EN so the same bench covers both builds.
module tb_uart_tx_ctrl;

    localparam int DBIT    = 8;
    localparam int OS      = 16;
    localparam int SB_TICK = 16;
`ifdef UART_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    localparam int FRAME_TICKS = (1 + DBIT + NPAR) * OS + SB_TICK;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            s_tick = 1'b0;
    logic [DBIT-1:0] tx_data = '0;
    logic            tx_valid = 1'b0;
    logic            parity_odd = 1'b0;
    logic            tx, tx_ready, tx_busy, tx_done_tick;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DBIT(DBIT), .OS(OS), .SB_TICK(SB_TICK)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .parity_odd   (parity_odd),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Oversample strobe: one pulse every tick_per clocks (1 = continuous).
    int tick_per = 4;
    int tick_ph = 0;
    initial forever begin
        @(posedge clk);
        #1;
        tick_ph = (tick_ph + 1 >= tick_per) ? 0 : tick_ph + 1;
        s_tick  = (tick_ph == 0);
    end

    // Reference: a frame is a sequence of FRAME_TICKS ticks; the line level is
    // a function of how many ticks have elapsed since the handshake.
    bit              m_act = 0;
    int              m_k = 0;
    logic [DBIT-1:0] m_data = '0;
    bit              m_odd = 0;
    logic            m_exp_tx = 1'b1;
    int              m_hs_cnt = 0;

    function automatic logic line_bit(input bit act, input int k,
                                      input logic [DBIT-1:0] d, input bit odd);
        int idx;
        if (!act) return 1'b1;
        idx = k / OS;
        if (idx == 0) return 1'b0;
        if (idx <= DBIT) return d[idx-1];
        if (NPAR == 1 && idx == DBIT + 1) return (^d) ^ odd;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_act    = 0;
            m_k      = 0;
            m_exp_tx = 1'b1;
        end else begin
            m_exp_tx = line_bit(m_act, m_k, m_data, m_odd);
            if (m_act) begin
                if (s_tick) begin
                    if (m_k == FRAME_TICKS - 1) m_act = 0;
                    m_k++;
                end
            end else if (tx_valid) begin
                m_act  = 1;
                m_k    = 0;
                m_data = tx_data;
                m_odd  = parity_odd;
                m_hs_cnt++;
            end
        end
    end

    int dut_done_cnt = 0;
    int len_cnt = 0;
    int last_len = 0;

    always @(negedge clk) begin
        logic [3:0] exp_v;
        if (!reset_n) exp_v = 4'b1100;
        else exp_v = {m_exp_tx, !m_act, m_act,
                      (m_act && s_tick && m_k == FRAME_TICKS - 1)};
        chk("cyc{tx,rdy,busy,done}", 32'({tx, tx_ready, tx_busy, tx_done_tick}), 32'(exp_v));
        if (!reset_n) begin
            len_cnt = 0;
        end else begin
            if (tx_busy && s_tick) len_cnt++;
            if (tx_done_tick) begin
                last_len = len_cnt;
                len_cnt  = 0;
                dut_done_cnt++;
            end
        end
    end

    task automatic send(input logic [DBIT-1:0] d, input bit hold_after);
        int hs0;
        int n;
        hs0 = m_hs_cnt;
        n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (m_hs_cnt == hs0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("hs_timeout", 32'(m_hs_cnt != hs0), 32'(1));
        if (!hold_after) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_act && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", 32'(m_act), 32'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input string tag, input logic [DBIT-1:0] d);
        int d0;
        d0 = dut_done_cnt;
        send(d, 1'b0);
        wait_idle();
        chk({tag, "_done"}, 32'(dut_done_cnt - d0), 32'(1));
        chk({tag, "_len"}, 32'(last_len), 32'(FRAME_TICKS));
    endtask

    initial begin
        int d0;
        int h0;
        int n;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_ready", 32'(tx_ready), 32'(1));

        frame("f55", 8'h55);

        // Back-to-back: valid held across both frames.
        d0 = dut_done_cnt;
        send(8'hA3, 1'b1);
        send(8'h3C, 1'b0);
        wait_idle();
        chk("b2b_done", 32'(dut_done_cnt - d0), 32'(2));
        chk("b2b_len", 32'(last_len), 32'(FRAME_TICKS));

        // Valid pulses and data churn while busy must be ignored.
        d0 = dut_done_cnt;
        h0 = m_hs_cnt;
        send(8'hC6, 1'b0);
        n = 0;
        while (m_k < 3 * OS && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 30; i++) begin
            tx_valid = 1'($urandom_range(0, 1));
            tx_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        tx_valid = 1'b0;
        wait_idle();
        chk("busy_ign_done", 32'(dut_done_cnt - d0), 32'(1));
        chk("busy_ign_hs", 32'(m_hs_cnt - h0), 32'(1));

        // Parity flag: even then odd; changing it mid-frame must not matter.
        parity_odd = 1'b0;
        send(8'h55, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        parity_odd = 1'b1;
        wait_idle();
        chk("par_even_len", 32'(last_len), 32'(FRAME_TICKS));
        frame("par_odd", 8'h55);
        parity_odd = 1'b0;

        tick_per = 1;
        frame("tick1", 8'h55);
        tick_per = 7;
        frame("tick7", 8'h55);

        d0 = dut_done_cnt;
        for (int i = 0; i < 6; i++) begin
            bit hold;
            tick_per   = $urandom_range(1, 6);
            parity_odd = 1'($urandom_range(0, 1));
            hold       = 1'($urandom_range(0, 1));
            send(8'($urandom), hold);
            if (!hold) begin
                wait_idle();
                repeat ($urandom_range(0, 9)) @(posedge clk);
                #1;
            end
        end
        tx_valid = 1'b0;
        wait_idle();
        chk("rand_done", 32'(dut_done_cnt - d0), 32'(6));
        chk("rand_len", 32'(last_len), 32'(FRAME_TICKS));

        // Reset in the middle of the data bits aborts the frame at once.
        tick_per = 4;
        d0 = dut_done_cnt;
        send(8'h0F, 1'b0);
        n = 0;
        while (m_k < 3 * OS && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        reset_n = 1'b0;
        #1;
        chk("rst_tx", 32'(tx), 32'(1));
        chk("rst_ready", 32'(tx_ready), 32'(1));
        chk("rst_busy", 32'(tx_busy), 32'(0));
        chk("rst_done", 32'(tx_done_tick), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        chk("rst_no_done", 32'(dut_done_cnt - d0), 32'(0));
        frame("after_rst", 8'h96);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
